seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 4-digit common-anode 7-segment display.

---
 rtl/seg7_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. One hex-to-segment decoder is shared by all four digits, and a
//   single active-low anode is rotated across them. Values arrive over a
//   valid/ready port into a pending buffer. That buffer is copied to the
//   display register only at a frame boundary, so a frame never shows a mix
//   of old and new digits.
//   Also provides leading-zero suppression, per-digit decimal points and a
//   blank interval at the start of each slot to stop ghosting.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active-low
//   en          scan enable (0 = hold scan position, display blanked)
//   lz_en       suppress leading zero digits
//   dp_mask     dp_mask[k] lights the decimal point of digit k (live)
//   load_data   value to show; nibble k -> digit k (digit0 = rightmost)
//   load_valid  load request
//   load_ready  load accepted when load_valid & load_ready at clk edge
//   an          anode enables, active-low, an[k] = digit k
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   digit_idx   digit slot currently being scanned
//   frame_tick  1-cycle pulse in the last cycle of each 4-digit frame

module seg7_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int DIV_W        = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        lz_en,
   input  logic [3:0]  dp_mask,
   input  logic [15:0] load_data,
   input  logic        load_valid,
   output logic        load_ready,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [1:0]  digit_idx,
   output logic        frame_tick
);

   localparam logic [DIV_W-1:0] CNT_LAST  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0] CNT_BLANK = DIV_W'(BLANK_CYCLES);

   // Active-low gfedcba decode.
   function automatic logic [6:0] hex_enc(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // A digit is a leading zero when it and every more significant nibble
   // are zero. Digit0 always shows, so an all-zero value reads "0".
   function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] k);
      logic z;
      case (k)
         2'd1:    z = (v[15:4] == 12'h000);
         2'd2:    z = (v[15:8] == 8'h00);
         2'd3:    z = (v[15:12] == 4'h0);
         default: z = 1'b0;
      endcase
      return z;
   endfunction

   logic [DIV_W-1:0] cnt_p0;
   logic [1:0]       idx_p0;
   logic [15:0]      disp;
   logic [15:0]      pend;
   logic             pend_full;
   logic             slot_end;
   logic             load_acc;
   logic [3:0]       nib_p0;
   logic             blank_p0;
   logic [3:0]       an_p1;
   logic [6:0]       seg_p1;
   logic             dp_p1;

   // ---- stage p0: slot counter, digit index, double buffer ----
   assign slot_end   = (cnt_p0 == CNT_LAST);
   assign frame_tick = en & slot_end & (idx_p0 == 2'd3);
   assign load_ready = ~pend_full;
   assign load_acc   = load_valid & ~pend_full;
   assign digit_idx  = idx_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p0 <= '0;
         idx_p0 <= 2'd0;
      end else if (en) begin
         if (slot_end) begin
            cnt_p0 <= '0;
            idx_p0 <= idx_p0 + 2'd1;
         end else begin
            cnt_p0 <= cnt_p0 + DIV_W'(1);
         end
      end
   end

   // Transfer and accept are mutually exclusive: accept needs pending empty,
   // transfer needs it full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp      <= 16'h0000;
         pend      <= 16'h0000;
         pend_full <= 1'b0;
      end else if (frame_tick && pend_full) begin
         disp      <= pend;
         pend_full <= 1'b0;
      end else if (load_acc) begin
         pend      <= load_data;
         pend_full <= 1'b1;
      end
   end

   assign nib_p0   = disp[{idx_p0, 2'b00} +: 4];
   assign blank_p0 = !en || (cnt_p0 < CNT_BLANK) || (lz_en && lead_zero(disp, idx_p0));

   // ---- stage p1: registered drive to the display pins ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_p1  <= 4'b1111;
         seg_p1 <= 7'b1111111;
         dp_p1  <= 1'b1;
      end else if (blank_p0) begin
         an_p1  <= 4'b1111;
         seg_p1 <= 7'b1111111;
         dp_p1  <= 1'b1;
      end else begin
         an_p1  <= ~(4'b0001 << idx_p0);
         seg_p1 <= hex_enc(nib_p0);
         dp_p1  <= ~dp_mask[idx_p0];
      end
   end

   assign an  = an_p1;
   assign seg = seg_p1;
   assign dp  = dp_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
//   Directed bench for seg7_scan_ctrl with REFRESH_DIV=4, BLANK_CYCLES=1.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge. A frame is 16 cycles: four slots of one blank cycle plus three
//   lit cycles.

module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        lz_en;
   logic [3:0]  dp_mask;
   logic [15:0] load_data;
   logic        load_valid;
   logic        load_ready;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   logic [6:0] enc_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   seg7_scan_ctrl #(
      .REFRESH_DIV  (4),
      .BLANK_CYCLES (1),
      .DIV_W        (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .lz_en      (lz_en),
      .dp_mask    (dp_mask),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected {an,seg,dp} for state s (0..15) of a frame showing v.
   function automatic logic [11:0] exp_out(input logic [15:0] v, input logic lz,
                                           input logic [3:0] dpm, input int s);
      int         k;
      int         c;
      logic [3:0] nib;
      logic       sup;
      k   = s / 4;
      c   = s % 4;
      nib = 4'((v >> (4 * k)) & 16'hF);
      sup = lz && (k >= 1) && ((v >> (4 * k)) == 16'h0000);
      if (c == 0 || sup) return 12'hFFF;
      return {~(4'b0001 << k), enc_tab[nib], ~dpm[k]};
   endfunction

   // Returns at a falling edge where frame_tick is high (possibly the current one).
   task automatic wait_tick(input string tag);
      int n = 0;
      while (frame_tick !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (frame_tick !== 1'b1) chk({tag, "_tick_timeout"}, 16'(frame_tick), 16'h1);
   endtask

   task automatic do_load(input logic [15:0] v);
      int n = 0;
      load_data  = v;
      load_valid = 1'b1;
      while (load_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (load_ready !== 1'b1) chk("load_timeout", 16'(load_ready), 16'h1);
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   // Current falling edge shows state s_cur; check states s_cur+1..14.
   // Ends on the falling edge where the next frame_tick is high.
   task automatic scan(input string tag, input logic [15:0] v, input logic lz,
                       input logic [3:0] dpm, input int s_cur);
      for (int s = s_cur + 1; s <= 14; s++) begin
         @(negedge clk);
         if (s >= 0) chk($sformatf("%s_s%0d", tag, s), 16'({an, seg, dp}), 16'(exp_out(v, lz, dpm, s)));
      end
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      en         = 1'b1;
      lz_en      = 1'b0;
      dp_mask    = 4'b0000;
      load_data  = 16'h0000;
      load_valid = 1'b0;

      // Reset values
      #23;
      chk("rst_out",   16'({an, seg, dp}), 16'hFFF);
      chk("rst_ready", 16'(load_ready), 16'h1);
      chk("rst_idx",   16'(digit_idx), 16'h0);
      chk("rst_tick",  16'(frame_tick), 16'h0);

      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_blank", 16'({an, seg, dp}), 16'hFFF);
      @(negedge clk);
      chk("rel_lit", 16'({an, seg, dp}), 16'(12'b1110_1000000_1));

      // Frame period
      wait_tick("period0");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 40);
      chk("tick_period", 16'(n), 16'd16);

      // Fill pending, then async reset mid-slot 2 discards it
      do_load(16'h1234);
      repeat (10) @(negedge clk);
      chk("slot2_lit",  16'({an, seg, dp}), 16'(12'b1011_1000000_1));
      chk("full_ready", 16'(load_ready), 16'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_out",   16'({an, seg, dp}), 16'hFFF);
      chk("async_ready", 16'(load_ready), 16'h1);
      chk("async_idx",   16'(digit_idx), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_tick("lost");
      repeat (3) @(negedge clk);
      chk("pend_lost", 16'({an, seg, dp}), 16'(12'b1110_1000000_1));

      // Load 0x1234, visible only after the next frame boundary
      do_load(16'h1234);
      wait_tick("l1234");
      chk("pre_1234", 16'({an, seg, dp}), 16'(12'b0111_1000000_1));
      scan("f1234", 16'h1234, 1'b0, 4'b0000, -2);

      // Every decode entry through digit0
      for (int v = 0; v < 16; v++) begin
         do_load(16'(v));
         wait_tick("enc");
         repeat (3) @(negedge clk);
         chk($sformatf("enc_%0h", v), 16'({an, seg, dp}), 16'({4'b1110, enc_tab[v], 1'b1}));
      end

      // Leading-zero suppression
      lz_en = 1'b1;
      do_load(16'h0007);
      wait_tick("lz7");
      scan("lz0007", 16'h0007, 1'b1, 4'b0000, -2);
      do_load(16'h0000);
      wait_tick("lz0");
      scan("lz0000", 16'h0000, 1'b1, 4'b0000, -2);
      do_load(16'h1000);
      wait_tick("lz1000");
      scan("lz1000", 16'h1000, 1'b1, 4'b0000, -2);
      do_load(16'h0100);
      wait_tick("lz0100");
      scan("lz0100", 16'h0100, 1'b1, 4'b0000, -2);
      lz_en = 1'b0;

      // Decimal point on digit1 only
      do_load(16'h1234);
      wait_tick("dp");
      dp_mask = 4'b0010;
      scan("dp", 16'h1234, 1'b0, 4'b0010, -2);
      dp_mask = 4'b0000;

      // Back-to-back loads: second stalls until the frame boundary
      do_load(16'hAAAA);
      load_data  = 16'h5555;
      load_valid = 1'b1;
      chk("b2b_stall", 16'(load_ready), 16'h0);
      wait_tick("b2b1");
      chk("b2b_tick_ready", 16'(load_ready), 16'h0);
      @(negedge clk);
      chk("b2b_rise", 16'(load_ready), 16'h1);
      @(negedge clk);
      load_valid = 1'b0;
      chk("b2b_taken", 16'(load_ready), 16'h0);
      scan("fAAAA", 16'hAAAA, 1'b0, 4'b0000, 0);
      wait_tick("b2b2");
      scan("f5555", 16'h5555, 1'b0, 4'b0000, -2);

      // Load presented in a frame_tick cycle with pending empty
      chk("tk_ready", 16'(load_ready), 16'h1);
      load_data  = 16'h0F0F;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      chk("tk_taken", 16'(load_ready), 16'h0);
      scan("f5555b", 16'h5555, 1'b0, 4'b0000, -1);
      wait_tick("tk");
      scan("f0F0F", 16'h0F0F, 1'b0, 4'b0000, -2);

      // Scan freeze mid-slot 1
      repeat (6) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("en0_out",  16'({an, seg, dp}), 16'hFFF);
      chk("en0_idx",  16'(digit_idx), 16'h1);
      chk("en0_tick", 16'(frame_tick), 16'h0);
      do_load(16'h8888);
      chk("en0_full", 16'(load_ready), 16'h0);
      load_data  = 16'h9999;
      load_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("en0_stall", 16'(load_ready), 16'h0);
      chk("en0_hold",  16'(digit_idx), 16'h1);
      chk("en0_dark",  16'({an, seg, dp}), 16'hFFF);
      load_valid = 1'b0;
      en = 1'b1;
      scan("resume", 16'h0F0F, 1'b0, 4'b0000, 4);
      wait_tick("resume");
      scan("f8888", 16'h8888, 1'b0, 4'b0000, -2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
